// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed little-endian byte stream, writes 32-bit words
// into instruction memory from address 0, and holds the CPU in reset until the image is in.
module imem_boot_loader #(
  parameter int unsigned IMEM_BYTES = 64,
  parameter int unsigned ADDR_W     = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [15:0]       words_loaded
);

  localparam int unsigned MAX_WORDS = IMEM_BYTES / 4;

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    LOAD = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  // Handshake: a byte transfers on a rising edge where rx_valid and rx_ready are both high;
  // rx_ready depends only on state and reset, never on rx_valid.
  state_t      state_q;
  logic [1:0]  idx_q;
  logic [23:0] asm_q;
  logic [15:0] n_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [15:0] words_q;
  logic        cpu_reset_q;
  logic        done_q;
  logic        err_q;

  logic        accept;
  logic [15:0] n_d;
  logic [15:0] words_d;

  assign rx_ready = ~reset & ((state_q == HDR0) | (state_q == HDR1) | (state_q == LOAD));
  assign accept   = rx_valid & rx_ready;
  assign n_d      = {rx_data, n_q[7:0]};
  assign words_d  = words_q + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HDR0;
      idx_q       <= 2'd0;
      asm_q       <= 24'd0;
      n_q         <= 16'd0;
      we_q        <= 1'b0;
      wdata_q     <= 32'd0;
      words_q     <= 16'd0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        HDR0: begin
          if (accept) begin
            n_q[7:0] <= rx_data;
            state_q  <= HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            n_q[15:8] <= rx_data;
            if (n_d == 16'd0)                 state_q <= DONE;
            else if (n_d > 16'(MAX_WORDS))    state_q <= ERR;
            else                              state_q <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            // Lane 3 completes the word; the write register is separate from the assembly
            // register so the next word's first byte can arrive during the write cycle.
            if (idx_q == 2'd3) begin
              we_q    <= 1'b1;
              wdata_q <= {rx_data, asm_q};
              words_q <= words_d;
              idx_q   <= 2'd0;
              if (words_d == n_q) state_q <= DONE;
            end else begin
              case (idx_q)
                2'd0:    asm_q[7:0]   <= rx_data;
                2'd1:    asm_q[15:8]  <= rx_data;
                default: asm_q[23:16] <= rx_data;
              endcase
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        DONE: begin
          cpu_reset_q <= 1'b0;
          done_q      <= 1'b1;
        end
        ERR: begin
          err_q <= 1'b1;
        end
        default: state_q <= HDR0;
      endcase
    end
  end

  // The write address is the pre-increment word count, so it is derived from the count
  // held alongside the write strobe (words_q - 1 while/after a write).
  logic [15:0] addr_word_q;
  always_ff @(posedge clk) begin
    if (reset)                                       addr_word_q <= 16'd0;
    else if (state_q == LOAD && accept && idx_q == 2'd3) addr_word_q <= words_q;
  end

  assign imem_we      = we_q;
  assign imem_addr    = {{(ADDR_W-18){1'b0}}, addr_word_q, 2'b00};
  assign imem_wdata   = wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;

endmodule
